// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the UART program loader:
//   - default instruction-memory address width and inter-word timeout
//   - FSM state encodings (plain constants so older tools can read them)
//   - small helpers for the length test and the running checksum
// -----------------------------------------------------------------------------
package loader_pkg;

   localparam int LOADER_ADDR_WIDTH     = 8;
   localparam int LOADER_TIMEOUT_CYCLES = 65536;

   localparam int         STATE_W = 3;
   localparam logic [2:0] ST_HDR  = 3'd0;  // waiting for the length word
   localparam logic [2:0] ST_DATA = 3'd1;  // receiving payload words
   localparam logic [2:0] ST_CHK  = 3'd2;  // waiting for the checksum word
   localparam logic [2:0] ST_DONE = 3'd3;  // image verified, CPU released
   localparam logic [2:0] ST_ERR  = 3'd4;  // frame rejected, CPU held

   // True when a requested length fits in 2**aw words. Done in 33 bits so a
   // full 32-bit header word can never alias onto a small legal length.
   function automatic logic length_fits(input logic [31:0] len,
                                        input int unsigned aw);
      logic [32:0] cap;
      cap = 33'd1 << aw;
      return ({1'b0, len} <= cap);
   endfunction

   // Running checksum is a plain XOR fold of the payload words.
   function automatic logic [31:0] checksum_next(input logic [31:0] sum,
                                                 input logic [31:0] word);
      return sum ^ word;
   endfunction

endpackage

// File: rtl/word_edge_detect.sv
// -----------------------------------------------------------------------------
// word_edge_detect
// Turns a level "word ready" flag, which the receiver may hold for several
// cycles, into a single-cycle accept pulse on its rising edge.
// Ports:
//   clk      - system clock
//   rst      - synchronous, active-high reset (clears the history bit)
//   i_ready  - receiver word-valid flag
//   o_accept - high in the cycle where i_ready=1 and it was 0 one cycle before
// -----------------------------------------------------------------------------
module word_edge_detect
(
   input  logic clk,
   input  logic rst,
   input  logic i_ready,
   output logic o_accept
);

   logic r_ready_q;

   // Remember last cycle's ready level.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ready_q <= 1'b0;
      end else begin
         r_ready_q <= i_ready;
      end
   end

   // Reset masks the pulse so a word coinciding with rst is discarded.
   assign o_accept = i_ready & ~r_ready_q & ~rst;

endmodule

// File: rtl/uart_program_loader.sv
// -----------------------------------------------------------------------------
// uart_program_loader
// Consumes 32-bit words from the UART word receiver and runs a framed
// download: length header, payload words, XOR checksum. Payload words are
// written to instruction memory; the CPU is held in reset until a frame with
// a matching checksum has been stored.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   RxD_word_data       - word from the receiver
//   RxD_word_data_ready - word-valid flag (level; rising edge accepts a word)
//   imem_we/addr/wdata  - one-cycle instruction-memory write port
//   cpu_rst             - processor reset, high until load succeeds
//   load_done           - sticky: image stored and checksum matched
//   load_error          - sticky: bad length, bad checksum or timeout
//   words_loaded        - payload words written so far
// -----------------------------------------------------------------------------
module uart_program_loader
   import loader_pkg::*;
#(
   parameter int ADDR_WIDTH     = LOADER_ADDR_WIDTH,
   parameter int TIMEOUT_CYCLES = LOADER_TIMEOUT_CYCLES
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           RxD_word_data,
   input  logic                  RxD_word_data_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_rst,
   output logic                  load_done,
   output logic                  load_error,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   localparam int              TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_TERM = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [STATE_W-1:0]    r_state;
   logic [ADDR_WIDTH:0]   r_len;
   logic [ADDR_WIDTH:0]   r_words_loaded;
   logic [31:0]           r_checksum;
   logic [TMO_W-1:0]      r_tmo;
   logic                  r_imem_we;
   logic [ADDR_WIDTH-1:0] r_imem_addr;
   logic [31:0]           r_imem_wdata;
   logic                  r_cpu_rst;
   logic                  r_load_done;
   logic                  r_load_error;

   logic                  w_accept;
   logic                  w_tmo_hit;
   logic [ADDR_WIDTH:0]   w_words_next;

   word_edge_detect u_edge
   (
      .clk      (clk),
      .rst      (rst),
      .i_ready  (RxD_word_data_ready),
      .o_accept (w_accept)
   );

   assign w_tmo_hit    = (r_tmo == TMO_TERM);
   assign w_words_next = r_words_loaded + (ADDR_WIDTH+1)'(1);

   // Frame FSM, write port, checksum and inter-word timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_HDR;
         r_len          <= '0;
         r_words_loaded <= '0;
         r_checksum     <= 32'd0;
         r_tmo          <= '0;
         r_imem_we      <= 1'b0;
         r_imem_addr    <= '0;
         r_imem_wdata   <= 32'd0;
         r_cpu_rst      <= 1'b1;
         r_load_done    <= 1'b0;
         r_load_error   <= 1'b0;
      end else begin
         r_imem_we <= 1'b0;
         case (r_state)
            ST_HDR: begin
               // The timeout only guards a frame that has started.
               r_tmo <= '0;
               if (w_accept) begin
                  r_len <= RxD_word_data[ADDR_WIDTH:0];
                  if (!length_fits(RxD_word_data, ADDR_WIDTH)) begin
                     r_state      <= ST_ERR;
                     r_load_error <= 1'b1;
                  end else if (RxD_word_data == 32'd0) begin
                     r_state <= ST_CHK;
                  end else begin
                     r_state <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (w_accept) begin
                  r_imem_we      <= 1'b1;
                  r_imem_addr    <= r_words_loaded[ADDR_WIDTH-1:0];
                  r_imem_wdata   <= RxD_word_data;
                  r_words_loaded <= w_words_next;
                  r_checksum     <= checksum_next(r_checksum, RxD_word_data);
                  r_tmo          <= '0;
                  if (w_words_next == r_len) begin
                     r_state <= ST_CHK;
                  end
               end else if (w_tmo_hit) begin
                  r_state      <= ST_ERR;
                  r_load_error <= 1'b1;
               end else begin
                  r_tmo <= r_tmo + TMO_W'(1);
               end
            end
            ST_CHK: begin
               if (w_accept) begin
                  r_tmo <= '0;
                  if (RxD_word_data == r_checksum) begin
                     r_state     <= ST_DONE;
                     r_load_done <= 1'b1;
                     r_cpu_rst   <= 1'b0;
                  end else begin
                     r_state      <= ST_ERR;
                     r_load_error <= 1'b1;
                  end
               end else if (w_tmo_hit) begin
                  r_state      <= ST_ERR;
                  r_load_error <= 1'b1;
               end else begin
                  r_tmo <= r_tmo + TMO_W'(1);
               end
            end
            ST_DONE: begin
               r_state <= ST_DONE;
            end
            ST_ERR: begin
               r_state <= ST_ERR;
            end
            default: begin
               // Corrupted state: fail safe with the CPU held.
               r_state      <= ST_ERR;
               r_load_done  <= 1'b0;
               r_load_error <= 1'b1;
               r_cpu_rst    <= 1'b1;
            end
         endcase
      end
   end

   assign imem_we      = r_imem_we;
   assign imem_addr    = r_imem_addr;
   assign imem_wdata   = r_imem_wdata;
   assign cpu_rst      = r_cpu_rst;
   assign load_done    = r_load_done;
   assign load_error   = r_load_error;
   assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_uart_program_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_program_loader
// Directed bench for uart_program_loader with ADDR_WIDTH=2, TIMEOUT_CYCLES=16.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_program_loader;

   logic        clk;
   logic        rst;
   logic [31:0] RxD_word_data;
   logic        RxD_word_data_ready;
   logic        imem_we;
   logic [1:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_rst;
   logic        load_done;
   logic        load_error;
   logic [2:0]  words_loaded;

   int n_checks = 0;
   int n_errors = 0;
   int n_writes = 0;
   int base_w;

   uart_program_loader #(.ADDR_WIDTH(2), .TIMEOUT_CYCLES(16)) dut
   (
      .clk                 (clk),
      .rst                 (rst),
      .RxD_word_data       (RxD_word_data),
      .RxD_word_data_ready (RxD_word_data_ready),
      .imem_we             (imem_we),
      .imem_addr           (imem_addr),
      .imem_wdata          (imem_wdata),
      .cpu_rst             (cpu_rst),
      .load_done           (load_done),
      .load_error          (load_error),
      .words_loaded        (words_loaded)
   );

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count write strobes seen at sample points.
   always @(negedge clk) begin
      if (imem_we === 1'b1) n_writes++;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, need completion");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, need 0x%08h", tag, got, exp);
      end
   endtask

   // Pulse rst for two cycles and check every output returns to reset value.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      RxD_word_data_ready = 1'b0;
      RxD_word_data = 32'd0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_val({tag, ".we"},    {31'd0, imem_we},    32'd0);
      check_val({tag, ".addr"},  {30'd0, imem_addr},  32'd0);
      check_val({tag, ".wdata"}, imem_wdata,          32'd0);
      check_val({tag, ".cpu"},   {31'd0, cpu_rst},    32'd1);
      check_val({tag, ".done"},  {31'd0, load_done},  32'd0);
      check_val({tag, ".err"},   {31'd0, load_error}, 32'd0);
      check_val({tag, ".words"}, {29'd0, words_loaded}, 32'd0);
   endtask

   // Present one word with a single-cycle ready pulse. Called and returns at a
   // falling edge; the cycle after acceptance is checked for the write strobe.
   task automatic send_word(input string tag, input logic [31:0] w,
                            input logic exp_we, input logic [31:0] exp_addr);
      RxD_word_data = w;
      RxD_word_data_ready = 1'b1;
      @(negedge clk);
      check_val({tag, ".we"}, {31'd0, imem_we}, {31'd0, exp_we});
      if (exp_we) begin
         check_val({tag, ".addr"},  {30'd0, imem_addr}, exp_addr);
         check_val({tag, ".wdata"}, imem_wdata, w);
      end
      RxD_word_data_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_status(input string tag, input logic done,
                               input logic err, input logic cpu,
                               input logic [31:0] words);
      check_val({tag, ".done"},  {31'd0, load_done},  {31'd0, done});
      check_val({tag, ".err"},   {31'd0, load_error}, {31'd0, err});
      check_val({tag, ".cpu"},   {31'd0, cpu_rst},    {31'd0, cpu});
      check_val({tag, ".words"}, {29'd0, words_loaded}, words);
   endtask

   initial begin
      rst = 1'b1;
      RxD_word_data = 32'd0;
      RxD_word_data_ready = 1'b0;
      @(negedge clk);

      // Nominal three-word load; checksum 0x0021182F.
      do_reset("rst0");
      base_w = n_writes;
      send_word("nom.hdr", 32'd3,         1'b0, 32'd0);
      send_word("nom.w0",  32'h20010005,  1'b1, 32'd0);
      send_word("nom.w1",  32'h2002000A,  1'b1, 32'd1);
      send_word("nom.w2",  32'h00221820,  1'b1, 32'd2);
      check_status("nom.pre", 1'b0, 1'b0, 1'b1, 32'd3);
      send_word("nom.chk", 32'h0021182F,  1'b0, 32'd0);
      check_status("nom.end", 1'b1, 1'b0, 1'b0, 32'd3);
      check_val("nom.nwr", n_writes - base_w, 32'd3);
      send_word("nom.ign", 32'h12345678,  1'b0, 32'd0);
      check_status("nom.abs", 1'b1, 1'b0, 1'b0, 32'd3);

      // Bad checksum.
      do_reset("rst1");
      send_word("bad.hdr", 32'd2,         1'b0, 32'd0);
      send_word("bad.w0",  32'h11111111,  1'b1, 32'd0);
      send_word("bad.w1",  32'h22222222,  1'b1, 32'd1);
      send_word("bad.chk", 32'h00000000,  1'b0, 32'd0);
      check_status("bad.end", 1'b0, 1'b1, 1'b1, 32'd2);
      send_word("bad.ign", 32'h33333333,  1'b0, 32'd0);
      check_status("bad.abs", 1'b0, 1'b1, 1'b1, 32'd2);

      // Header longer than capacity (4 words).
      do_reset("rst2");
      base_w = n_writes;
      send_word("len5.hdr", 32'd5, 1'b0, 32'd0);
      check_status("len5", 1'b0, 1'b1, 1'b1, 32'd0);
      send_word("len5.ign", 32'd1, 1'b0, 32'd0);
      check_val("len5.nwr", n_writes - base_w, 32'd0);

      // Full-capacity load; checksum 1^2^3^4 = 4.
      do_reset("rst3");
      send_word("len4.hdr", 32'd4, 1'b0, 32'd0);
      send_word("len4.w0",  32'd1, 1'b1, 32'd0);
      send_word("len4.w1",  32'd2, 1'b1, 32'd1);
      send_word("len4.w2",  32'd3, 1'b1, 32'd2);
      send_word("len4.w3",  32'd4, 1'b1, 32'd3);
      send_word("len4.chk", 32'd4, 1'b0, 32'd0);
      check_status("len4.end", 1'b1, 1'b0, 1'b0, 32'd4);

      // Ready held for 10 cycles on header 0. A second acceptance would
      // match the zero checksum and finish the load early.
      do_reset("rst4");
      base_w = n_writes;
      RxD_word_data = 32'd0;
      RxD_word_data_ready = 1'b1;
      repeat (10) @(negedge clk);
      RxD_word_data_ready = 1'b0;
      @(negedge clk);
      check_status("held", 1'b0, 1'b0, 1'b1, 32'd0);
      send_word("zero.chk", 32'd0, 1'b0, 32'd0);
      check_status("zero.end", 1'b1, 1'b0, 1'b0, 32'd0);
      check_val("zero.nwr", n_writes - base_w, 32'd0);

      // Timeout: send_word returns one edge after acceptance, so 14 more
      // edges make 15 (no error yet) and the next makes 16 (error).
      do_reset("rst5");
      send_word("tmo.hdr", 32'd2, 1'b0, 32'd0);
      send_word("tmo.w0",  32'hA5A5A5A5, 1'b1, 32'd0);
      repeat (14) @(negedge clk);
      check_val("tmo.15", {31'd0, load_error}, 32'd0);
      @(negedge clk);
      check_status("tmo.16", 1'b0, 1'b1, 1'b1, 32'd1);

      // Word arriving on the terminal-count cycle is accepted.
      do_reset("rst6");
      send_word("term.hdr", 32'd2, 1'b0, 32'd0);
      send_word("term.w0",  32'h0000F00F, 1'b1, 32'd0);
      repeat (14) @(negedge clk);
      send_word("term.w1",  32'h00FF0000, 1'b1, 32'd1);
      check_status("term.mid", 1'b0, 1'b0, 1'b1, 32'd2);
      send_word("term.chk", 32'h00FFF00F, 1'b0, 32'd0);
      check_status("term.end", 1'b1, 1'b0, 1'b0, 32'd2);

      // Reset mid-frame, then a fresh one-word load.
      do_reset("rst7");
      send_word("mid.hdr", 32'd3, 1'b0, 32'd0);
      send_word("mid.w0",  32'h0BADF00D, 1'b1, 32'd0);
      do_reset("midrst");
      send_word("mid2.hdr", 32'd1,        1'b0, 32'd0);
      send_word("mid2.w0",  32'hDEADBEEF, 1'b1, 32'd0);
      send_word("mid2.chk", 32'hDEADBEEF, 1'b0, 32'd0);
      check_status("mid2.end", 1'b1, 1'b0, 1'b0, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
